lsu_mem_adapter: RTL and testbench

- Load/store adapter between the core's memory-access stage and the 32-bit word-addressed RAM.
- Accepts one byte/halfword/word load or store at a time and converts byte addresses to word addresses.
- Sub-word stores use read-modify-write; loads are sign- or zero-extended.
- Issues single-cycle mem_en pulses and waits for the RAM's registered ack.

---
 rtl/lsu_mem_adapter.sv | 201 ++++++++++++++++++++
 tb/tb_lsu_mem_adapter.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_adapter.sv
// lsu_mem_adapter: load/store adapter between the core's memory stage and a
// 32-bit word-addressed RAM with a registered, next-cycle ack.
// Accepts one request at a time and converts the byte address to a word address.
// Byte and halfword stores are done as read-modify-write; loads are sign- or
// zero-extended.
// Optional build macro MISALIGN_TRAP_EN: when defined, misaligned halfword/word
// requests are answered with resp_err_o = 1 and never reach the RAM.
module lsu_mem_adapter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32     // fixed at 32, other widths unsupported
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_write_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    input  logic [31:0]       req_addr_i,
    input  logic [DATA_W-1:0] req_wdata_i,
    output logic              resp_valid_o,
    output logic [DATA_W-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic              mem_en_o,
    output logic              mem_write_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
);

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_RD_WAIT,
        S_WR,
        S_WR_WAIT,
        S_RESP
    } state_e;

    state_e              state_q;

    // Latched request
    logic [1:0]          lane_q;
    logic [1:0]          size_q;
    logic                unsigned_q;
    logic                write_q;
    logic [DATA_W-1:0]   wdata_q;

    // Registered outputs
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [DATA_W-1:0]   mem_wdata_q;
    logic                mem_en_q;
    logic                mem_write_q;
    logic                resp_valid_q;
    logic [DATA_W-1:0]   resp_rdata_q;
    logic                resp_err_q;

    logic                accept;
    logic                misalign;
    logic [7:0]          byte_lane;
    logic [15:0]         half_lane;
    logic [DATA_W-1:0]   load_data_d;
    logic [DATA_W-1:0]   merge_data_d;

    // Address bits above the RAM's word range wrap and are deliberately dropped.
    logic                unused_addr_hi;
    assign unused_addr_hi = ^req_addr_i[31:ADDR_W+2];

    assign req_ready_o = (state_q == S_IDLE);
    assign accept      = req_valid_i && req_ready_o;

`ifdef MISALIGN_TRAP_EN
    assign misalign = ((req_size_i == SIZE_HALF) && req_addr_i[0]) ||
                      (req_size_i[1] && (req_addr_i[1:0] != 2'b00));
`else
    // Offending low address bits are simply ignored by the lane select.
    assign misalign = 1'b0;
`endif

    assign byte_lane = mem_rdata_i[{lane_q, 3'b000} +: 8];
    assign half_lane = lane_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

    // Load path: pick the addressed lane of the returned word and extend it.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        load_data_d = mem_rdata_i;
        case (size_q)
            SIZE_BYTE: load_data_d = {{24{~unsigned_q & byte_lane[7]}}, byte_lane};
            SIZE_HALF: load_data_d = {{16{~unsigned_q & half_lane[15]}}, half_lane};
            default:   load_data_d = mem_rdata_i;
        endcase
    end

    // Store path: overlay the store data onto the addressed lane of the old word.
    always_comb begin
        merge_data_d = mem_rdata_i;
        case (size_q)
            SIZE_BYTE: merge_data_d[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
            SIZE_HALF: begin
                if (lane_q[1]) merge_data_d[31:16] = wdata_q[15:0];
                else           merge_data_d[15:0]  = wdata_q[15:0];
            end
            default:   merge_data_d = wdata_q;
        endcase
    end

    // Request sequencer: state plus every registered output in one place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            lane_q       <= '0;
            size_q       <= '0;
            unsigned_q   <= 1'b0;
            write_q      <= 1'b0;
            wdata_q      <= '0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            mem_en_q     <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments here so every register samples the
            // pre-edge values; the pulses below default low and are raised for
            // exactly one cycle.
            mem_en_q     <= 1'b0;
            resp_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        lane_q     <= req_addr_i[1:0];
                        size_q     <= req_size_i;
                        unsigned_q <= req_unsigned_i;
                        write_q    <= req_write_i;
                        wdata_q    <= req_wdata_i;
                        if (misalign) begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b1;
                            resp_rdata_q <= '0;
                        end else begin
                            mem_addr_q <= req_addr_i[ADDR_W+1:2];
                            mem_en_q   <= 1'b1;
                            if (req_write_i && req_size_i[1]) begin
                                state_q     <= S_WR;
                                mem_write_q <= 1'b1;
                                mem_wdata_q <= req_wdata_i;
                            end else begin
                                state_q     <= S_RD;
                                mem_write_q <= 1'b0;
                            end
                        end
                    end
                end
                S_RD: state_q <= S_RD_WAIT;
                S_RD_WAIT: begin
                    if (mem_ack_i) begin
                        if (write_q) begin
                            // Second half of a read-modify-write, same word address.
                            state_q     <= S_WR;
                            mem_en_q    <= 1'b1;
                            mem_write_q <= 1'b1;
                            mem_wdata_q <= merge_data_d;
                        end else begin
                            state_q      <= S_RESP;
                            resp_valid_q <= 1'b1;
                            resp_err_q   <= 1'b0;
                            resp_rdata_q <= load_data_d;
                        end
                    end
                end
                S_WR: state_q <= S_WR_WAIT;
                S_WR_WAIT: begin
                    if (mem_ack_i) begin
                        state_q      <= S_RESP;
                        resp_valid_q <= 1'b1;
                        resp_err_q   <= 1'b0;
                        resp_rdata_q <= '0;
                    end
                end
                S_RESP:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign mem_addr_o   = mem_addr_q;
    assign mem_wdata_o  = mem_wdata_q;
    assign mem_en_o     = mem_en_q;
    assign mem_write_o  = mem_write_q;
    assign resp_valid_o = resp_valid_q;
    assign resp_rdata_o = resp_rdata_q;
    assign resp_err_o   = resp_err_q;

endmodule

// File: tb/tb_lsu_mem_adapter.sv
// Self-checking bench for lsu_mem_adapter: table of directed load/store
// vectors against a behavioural RAM, plus reset and stray-ack sequences.
module tb_lsu_mem_adapter;

    localparam int ADDR_W = 8;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_unsigned = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_en;
    logic        mem_write;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    int n_pass = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    lsu_mem_adapter #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req_valid_i    (req_valid),
        .req_ready_o    (req_ready),
        .req_write_i    (req_write),
        .req_size_i     (req_size),
        .req_unsigned_i (req_unsigned),
        .req_addr_i     (req_addr),
        .req_wdata_i    (req_wdata),
        .resp_valid_o   (resp_valid),
        .resp_rdata_o   (resp_rdata),
        .resp_err_o     (resp_err),
        .mem_addr_o     (mem_addr),
        .mem_wdata_o    (mem_wdata),
        .mem_en_o       (mem_en),
        .mem_write_o    (mem_write),
        .mem_rdata_i    (mem_rdata),
        .mem_ack_i      (mem_ack)
    );

    // Behavioural RAM: registered read data and ack one cycle after mem_en.
    logic [31:0] ram [0:255];
    logic        ram_ack = 1'b0;
    logic [31:0] ram_rdata = '0;
    logic        stray_ack = 1'b0;
    logic        pre_en = 1'b0;
    logic [7:0]  pre_addr = '0;
    logic [31:0] pre_data = '0;

    always @(posedge clk) begin
        ram_ack <= 1'b0;
        if (pre_en) ram[pre_addr] <= pre_data;
        if (mem_en) begin
            ram_ack <= 1'b1;
            if (mem_write) ram[mem_addr] <= mem_wdata;
            else           ram_rdata <= ram[mem_addr];
        end
    end

    assign mem_rdata = ram_rdata;
    assign mem_ack   = ram_ack | stray_ack;

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wd;
        logic        pre;
        logic [31:0] pre_word;
        logic        chk_rdata;
        logic [31:0] exp_rdata;
        int          exp_lat;
        int          exp_ens;
        logic        exp_err;
        logic [31:0] exp_word;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic preload(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        pre_en = 1'b1; pre_addr = a; pre_data = d;
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic do_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rdata, output logic err,
                          output int ens, output logic [7:0] last_addr,
                          output logic [31:0] last_wdata);
        lat = -1; rdata = '0; err = 1'b0; ens = 0; last_addr = '0; last_wdata = '0;
        @(negedge clk);
        req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
        req_addr = addr; req_wdata = wd;
        @(posedge clk);
        for (int k = 1; k <= 20 && lat < 0; k++) begin
            @(negedge clk);
            req_valid = 1'b0;
            if (mem_en) begin
                ens++;
                last_addr = mem_addr;
                if (mem_write) last_wdata = mem_wdata;
            end
            if (resp_valid) begin
                lat = k; rdata = resp_rdata; err = resp_err;
            end
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [1:0] sz, input logic uns,
                                input logic [31:0] addr, input logic [31:0] wd,
                                input logic pre, input logic [31:0] pw,
                                input logic cr, input logic [31:0] er, input int el,
                                input int en, input logic ee, input logic [31:0] ew);
        vec_t v;
        v.wr = wr; v.sz = sz; v.uns = uns; v.addr = addr; v.wd = wd;
        v.pre = pre; v.pre_word = pw; v.chk_rdata = cr; v.exp_rdata = er;
        v.exp_lat = el; v.exp_ens = en; v.exp_err = ee; v.exp_word = ew;
        return v;
    endfunction

    vec_t vecs [15];

    initial begin
        int          lat;
        int          ens;
        logic [31:0] rdata;
        logic [31:0] lw;
        logic [7:0]  la;
        logic [7:0]  widx;
        logic        err;
        logic        activity;

        //            wr sz uns addr         wdata         pre pre_word      chk exp_rdata     lat            ens           err   word
        vecs[0]  = mk(1, 2, 0, 32'h10,  32'hDEADBEEF, 1, 32'h0,        1, 32'h0,        3,             1,            0,    32'hDEADBEEF);
        vecs[1]  = mk(0, 2, 0, 32'h10,  32'h0,        0, 32'h0,        1, 32'hDEADBEEF, 3,             1,            0,    32'hDEADBEEF);
        vecs[2]  = mk(1, 0, 0, 32'h11,  32'h000000AA, 1, 32'h11223344, 1, 32'h0,        5,             2,            0,    32'h1122AA44);
        vecs[3]  = mk(0, 0, 0, 32'h13,  32'h0,        1, 32'h80FF7F01, 1, 32'hFFFFFF80, 3,             1,            0,    32'h80FF7F01);
        vecs[4]  = mk(0, 0, 1, 32'h13,  32'h0,        0, 32'h0,        1, 32'h00000080, 3,             1,            0,    32'h80FF7F01);
        vecs[5]  = mk(0, 0, 0, 32'h11,  32'h0,        0, 32'h0,        1, 32'h0000007F, 3,             1,            0,    32'h80FF7F01);
        vecs[6]  = mk(0, 0, 0, 32'h12,  32'h0,        0, 32'h0,        1, 32'hFFFFFFFF, 3,             1,            0,    32'h80FF7F01);
        vecs[7]  = mk(0, 1, 0, 32'h12,  32'h0,        1, 32'h80017FFF, 1, 32'hFFFF8001, 3,             1,            0,    32'h80017FFF);
        vecs[8]  = mk(0, 1, 0, 32'h10,  32'h0,        0, 32'h0,        1, 32'h00007FFF, 3,             1,            0,    32'h80017FFF);
        vecs[9]  = mk(0, 1, 1, 32'h12,  32'h0,        0, 32'h0,        1, 32'h00008001, 3,             1,            0,    32'h80017FFF);
        vecs[10] = mk(1, 1, 0, 32'h16,  32'h1234BEEF, 1, 32'h11223344, 1, 32'h0,        5,             2,            0,    32'hBEEF3344);
        vecs[11] = mk(0, 3, 0, 32'h14,  32'h0,        0, 32'h0,        1, 32'hBEEF3344, 3,             1,            0,    32'hBEEF3344);
        vecs[12] = mk(0, 2, 0, 32'h410, 32'h0,        1, 32'hCAFEF00D, 1, 32'hCAFEF00D, 3,             1,            0,    32'hCAFEF00D);
        vecs[13] = mk(0, 1, 0, 32'h11,  32'h0,        1, 32'hA5A55A5A, !TRAP, 32'h00005A5A, TRAP ? 1 : 3, TRAP ? 0 : 1, TRAP, 32'hA5A55A5A);
        vecs[14] = mk(1, 2, 0, 32'h12,  32'h0BADF00D, 1, 32'h11111111, !TRAP, 32'h0,        TRAP ? 1 : 3, TRAP ? 0 : 1, TRAP,
                      TRAP ? 32'h11111111 : 32'h0BADF00D);

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_rdata", resp_rdata, 32'h0);
        check("rst_resp_err", 32'(resp_err), 32'h0);
        check("rst_mem_en", 32'(mem_en), 32'h0);
        check("rst_mem_write", 32'(mem_write), 32'h0);
        check("rst_mem_addr", 32'(mem_addr), 32'h0);
        check("rst_mem_wdata", mem_wdata, 32'h0);
        rst_n = 1'b1;

        // Table-driven vectors
        for (int i = 0; i < 15; i++) begin
            widx = vecs[i].addr[9:2];
            if (vecs[i].pre) preload(widx, vecs[i].pre_word);
            do_req(vecs[i].wr, vecs[i].sz, vecs[i].uns, vecs[i].addr, vecs[i].wd,
                   lat, rdata, err, ens, la, lw);
            if (vecs[i].chk_rdata) check($sformatf("v%0d_rdata", i), rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_mem_en_pulses", i), 32'(ens), 32'(vecs[i].exp_ens));
            check($sformatf("v%0d_err", i), 32'(err), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_ram_word", i), ram[widx], vecs[i].exp_word);
            if (vecs[i].exp_ens > 0) check($sformatf("v%0d_mem_addr", i), 32'(la), 32'(widx));
            if (vecs[i].wr && vecs[i].exp_ens > 0)
                check($sformatf("v%0d_mem_wdata", i), lw, vecs[i].exp_word);
        end

        // Reset during RD_WAIT of a byte store: no response, word untouched.
        preload(8'd6, 32'h11223344);
        @(negedge clk);
        req_valid = 1'b1; req_write = 1'b1; req_size = 2'd0; req_unsigned = 1'b0;
        req_addr = 32'h18; req_wdata = 32'h55;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check("abort_read_issued", 32'(mem_en & ~mem_write), 32'h1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_req_ready", 32'(req_ready), 32'h1);
        check("abort_resp_valid", 32'(resp_valid), 32'h0);
        check("abort_mem_en", 32'(mem_en), 32'h0);
        check("abort_mem_write", 32'(mem_write), 32'h0);
        check("abort_mem_addr", 32'(mem_addr), 32'h0);
        check("abort_mem_wdata", mem_wdata, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Stray ack while idle must not produce any activity.
        activity = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (k > 0) activity = activity | resp_valid | mem_en | ~req_ready;
            stray_ack = (k == 0);
        end
        check("stray_ack_ignored", 32'(activity), 32'h0);
        check("abort_word_unchanged", ram[6], 32'h11223344);

        // Normal operation resumes.
        do_req(1'b0, 2'd0, 1'b0, 32'h18, 32'h0, lat, rdata, err, ens, la, lw);
        check("post_rst_rdata", rdata, 32'h00000044);
        check("post_rst_latency", 32'(lat), 32'd3);
        do_req(1'b1, 2'd0, 1'b0, 32'h1B, 32'h000000EE, lat, rdata, err, ens, la, lw);
        check("post_rst_store_latency", 32'(lat), 32'd5);
        check("post_rst_store_word", ram[6], 32'hEE223344);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
